// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Two-port arbiter for a single-port RAM with registered read data.
//             RAM_ARB_RR_EN selects round-robin tie-break (default: port 0 wins).
//  Revision : 1.0
// ============================================================================
module ram_arbiter #(
   parameter int AW = 4,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          ack0,
   output logic [DW-1:0] rdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          ack1,
   output logic [DW-1:0] rdata1,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout,
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ACCESS    = 2'd1,
      READ_WAIT = 2'd2,
      ACK       = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic            owner_q, owner_d;
   logic            we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [DW-1:0]   rdata0_q, rdata0_d;
   logic [DW-1:0]   rdata1_q, rdata1_d;
   logic            grant1;

`ifdef RAM_ARB_RR_EN
   logic            last_q, last_d;

   // On a tie, the port that did not win the previous grant goes first.
   assign grant1 = req1 && (!req0 || !last_q);
`else
   assign grant1 = req1 && !req0;
`endif

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
`ifdef RAM_ARB_RR_EN
      last_d   = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               owner_d = grant1;
               we_d    = grant1 ? we1    : we0;
               addr_d  = grant1 ? addr1  : addr0;
               wdata_d = grant1 ? wdata1 : wdata0;
               state_d = ACCESS;
`ifdef RAM_ARB_RR_EN
               last_d  = grant1;
`endif
            end
         end
         ACCESS: begin
            state_d = we_q ? ACK : READ_WAIT;
         end
         READ_WAIT: begin
            if (owner_q) begin
               rdata1_d = ram_dout;
            end else begin
               rdata0_d = ram_dout;
            end
            state_d = ACK;
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
`ifdef RAM_ARB_RR_EN
         last_q   <= 1'b1;
`endif
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
`ifdef RAM_ARB_RR_EN
         last_q   <= last_d;
`endif
      end
   end

   // Reset gates the write strobe combinationally so an aborted ACCESS never commits.
   assign ram_we   = (state_q == ACCESS) && we_q && !rst;
   assign ram_addr = addr_q;
   assign ram_din  = wdata_q;
   assign ack0     = (state_q == ACK) && !owner_q;
   assign ack1     = (state_q == ACK) &&  owner_q;
   assign rdata0   = rdata0_q;
   assign rdata1   = rdata1_q;
   assign busy     = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_arbiter
//  Purpose  : Directed self-checking bench for ram_arbiter with a behavioural
//             RAM (registered read). Honours RAM_ARB_RR_EN for tie expectations.
//  Revision : 1.0
// ============================================================================
module tb_ram_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, we0, req1, we1;
   logic [3:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic       ack0, ack1;
   logic [7:0] rdata0, rdata1;
   logic       ram_we;
   logic [3:0] ram_addr;
   logic [7:0] ram_din;
   logic [7:0] ram_dout;
   logic       busy;

   int n_chk  = 0;
   int n_pass = 0;

   logic [7:0] mem [16];
   logic       mem_ready = 1'b0;

   ram_arbiter #(.AW(4), .DW(8)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Word i starts as 8'h50+i so untouched addresses have known contents.
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 16; i++) mem[i] <= 8'h50 + 8'(i);
         mem_ready <= 1'b1;
      end else begin
         if (ram_we) mem[ram_addr] <= ram_din;
         ram_dout <= mem[ram_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic ack_of(input int p);
      return (p == 0) ? ack0 : ack1;
   endfunction

   function automatic logic [7:0] rdata_of(input int p);
      return (p == 0) ? rdata0 : rdata1;
   endfunction

   task automatic set_req(input int p, input logic r, input logic w,
                          input logic [3:0] a, input logic [7:0] d);
      if (p == 0) begin
         req0 = r; we0 = w; addr0 = a; wdata0 = d;
      end else begin
         req1 = r; we1 = w; addr1 = a; wdata1 = d;
      end
   endtask

   // Called at a negedge in IDLE; returns at a negedge in IDLE.
   task automatic xact(input string tag, input int p, input logic w,
                       input logic [3:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
      set_req(p, 1'b1, w, a, d);
      @(negedge clk);
      check({tag, " access busy"}, busy, 1);
      check({tag, " access ram_we"}, ram_we, w);
      check({tag, " access ram_addr"}, ram_addr, a);
      if (w) check({tag, " access ram_din"}, ram_din, d);
      set_req(p, 1'b0, w, a, d);
      if (!w) begin
         @(negedge clk);
         check({tag, " read_wait ack"}, ack_of(p), 0);
         check({tag, " read_wait busy"}, busy, 1);
      end
      @(negedge clk);
      check({tag, " ack"}, ack_of(p), 1);
      check({tag, " other ack"}, ack_of(1 - p), 0);
      check({tag, " ack busy"}, busy, 1);
      check({tag, " ack ram_we"}, ram_we, 0);
      if (!w) check({tag, " rdata"}, rdata_of(p), exp_rd);
      @(negedge clk);
      check({tag, " post ack"}, ack_of(p), 0);
      check({tag, " post busy"}, busy, 0);
   endtask

   // Both ports write simultaneously; `first` is the expected winner.
   task automatic tie(input string tag, input int first,
                      input logic [3:0] a0, input logic [7:0] d0,
                      input logic [3:0] a1, input logic [7:0] d1);
      logic [3:0] fa, sa;
      int second;
      second = 1 - first;
      fa = (first == 0) ? a0 : a1;
      sa = (first == 0) ? a1 : a0;
      set_req(0, 1'b1, 1'b1, a0, d0);
      set_req(1, 1'b1, 1'b1, a1, d1);
      @(negedge clk);
      check({tag, " first addr"}, ram_addr, fa);
      check({tag, " first we"}, ram_we, 1);
      if (first == 0) req0 = 1'b0; else req1 = 1'b0;
      @(negedge clk);
      check({tag, " first ack"}, ack_of(first), 1);
      check({tag, " second no ack"}, ack_of(second), 0);
      @(negedge clk);
      check({tag, " gap idle"}, busy, 0);
      @(negedge clk);
      check({tag, " second addr"}, ram_addr, sa);
      if (second == 0) req0 = 1'b0; else req1 = 1'b0;
      @(negedge clk);
      check({tag, " second ack"}, ack_of(second), 1);
      @(negedge clk);
      check({tag, " end idle"}, busy, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
      req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
      @(negedge clk);
      @(negedge clk);
      check("reset ack0", ack0, 0);
      check("reset ack1", ack1, 0);
      check("reset busy", busy, 0);
      check("reset ram_we", ram_we, 0);
      check("reset ram_addr", ram_addr, 0);
      check("reset ram_din", ram_din, 0);
      check("reset rdata0", rdata0, 0);
      check("reset rdata1", rdata1, 0);
      rst = 1'b0;

      xact("V1 write", 0, 1'b1, 4'd3, 8'hA5, 8'h00);
      xact("V2 read", 1, 1'b0, 4'd3, 8'h00, 8'hA5);
      check("V2 rdata0 unchanged", rdata0, 8'h00);
      xact("V5 write top", 0, 1'b1, 4'd15, 8'hFF, 8'h00);
      xact("V5 read top", 1, 1'b0, 4'd15, 8'h00, 8'hFF);

      // V6: request withdrawn during READ_WAIT
      set_req(0, 1'b1, 1'b0, 4'd3, 8'h00);
      @(negedge clk);
      check("V6 access", ram_addr, 4'd3);
      @(negedge clk);
      check("V6 read_wait busy", busy, 1);
      req0 = 1'b0;
      @(negedge clk);
      check("V6 ack0", ack0, 1);
      check("V6 rdata0", rdata0, 8'hA5);
      @(negedge clk);
      check("V6 idle", busy, 0);

      xact("P1 write", 1, 1'b1, 4'd7, 8'h77, 8'h00);
      check("write keeps rdata1", rdata1, 8'hFF);

      do_reset();
      tie("V3 tie", 0, 4'd0, 8'h11, 4'd1, 8'h22);
      xact("V3 p0 write", 0, 1'b1, 4'd2, 8'h33, 8'h00);
`ifdef RAM_ARB_RR_EN
      tie("V3 next tie", 1, 4'd8, 8'h88, 4'd9, 8'h99);
`else
      tie("V3 next tie", 0, 4'd8, 8'h88, 4'd9, 8'h99);
`endif

      // V4: reset during the ACCESS cycle of a write
      set_req(0, 1'b1, 1'b1, 4'd5, 8'h3C);
      @(negedge clk);
      check("V4 access pre-rst we", ram_we, 1);
      rst = 1'b1;
      #1;
      check("V4 rst gates ram_we", ram_we, 0);
      req0 = 1'b0;
      @(negedge clk);
      check("V4 no ack0", ack0, 0);
      check("V4 idle", busy, 0);
      rst = 1'b0;
      @(negedge clk);
      check("V4 still no ack0", ack0, 0);
      xact("V4 readback", 0, 1'b0, 4'd5, 8'h00, 8'h55);
      xact("V3 readback", 1, 1'b0, 4'd1, 8'h00, 8'h22);
      xact("tie readback", 0, 1'b0, 4'd9, 8'h00, 8'h99);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
